// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared opcodes, scoreboard entry type and source-operand decode for the load-use hazard unit.
package hazard_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam int unsigned SB_RD_W  = 5;
    localparam int unsigned SB_CNT_W = 8;

    typedef struct packed {
        logic                valid;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

    typedef struct packed {
        logic       uses_rs1;
        logic       uses_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } src_t;

    // Unknown opcodes are treated as rs1 readers so they stall conservatively.
    function automatic src_t src_decode(input logic [31:0] inst);
        src_t s;
        s.rs1      = inst[19:15];
        s.rs2      = inst[24:20];
        s.uses_rs1 = !(inst[6:0] inside {LUI, AUIPC, JAL});
        s.uses_rs2 = inst[6:0] inside {OP, STORE, BRANCH};
        return s;
    endfunction

endpackage

// File: rtl/load_hazard_scoreboard_sb_entry.sv
// One scoreboard slot: an in-flight load's destination and the cycles left until it is forwardable.
module hazard_sb_entry
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc,
    input  logic [SB_RD_W-1:0]  alloc_rd,
    input  logic [SB_CNT_W-1:0] alloc_cnt,
    input  logic [SB_RD_W-1:0]  rs_a,
    input  logic [SB_RD_W-1:0]  rs_b,
    output logic                free,
    output logic                match_a,
    output logic                match_b
);

    sb_entry_t entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (alloc) begin
            entry <= '{valid: 1'b1, rd: alloc_rd, cnt: alloc_cnt};
        end else if (entry.valid) begin
            entry.valid <= (entry.cnt != SB_CNT_W'(1));
            entry.cnt   <= entry.cnt - SB_CNT_W'(1);
        end
    end

    // A slot in its last cycle is reusable at the same edge it expires.
    assign free    = !entry.valid || (entry.cnt == SB_CNT_W'(1));
    assign match_a = entry.valid && (entry.rd == rs_a);
    assign match_b = entry.valid && (entry.rd == rs_b);

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit beside ID: tracks loads not yet forwardable and raises stall/hold/bubble.
// Optional stall-cycle statistics counter enabled by defining HAZARD_STATS_EN.
module load_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [31:0]       id_inst,
    input  logic              flush,
    output logic              stall,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic [31:0]       stall_cnt
);

    if (DEPTH < LOAD_LAT - 1) begin : g_bad_depth
        $error("load_hazard_scoreboard: DEPTH must be at least LOAD_LAT-1");
    end
    if (REG_AW > SB_RD_W || LOAD_LAT - 1 >= (1 << SB_CNT_W)) begin : g_bad_width
        $error("load_hazard_scoreboard: REG_AW or LOAD_LAT exceeds entry field width");
    end

    src_t               src;
    logic [SB_RD_W-1:0] rs_a;
    logic [SB_RD_W-1:0] rs_b;
    logic [SB_RD_W-1:0] ex_rd_w;
    logic               alloc_req;
    logic               ex_hit;
    logic               sb_hit;
    logic               any_free;
    logic [DEPTH-1:0]   alloc_vec;
    logic [DEPTH-1:0]   free_vec;
    logic [DEPTH-1:0]   match_a_vec;
    logic [DEPTH-1:0]   match_b_vec;

    assign src     = src_decode(id_inst);
    // Unused or x0 sources map to x0, which no entry ever holds.
    assign rs_a    = src.uses_rs1 ? SB_RD_W'(src.rs1) : '0;
    assign rs_b    = src.uses_rs2 ? SB_RD_W'(src.rs2) : '0;
    assign ex_rd_w = SB_RD_W'(ex_rd);

    assign alloc_req = ex_valid && ex_memread && (ex_rd != '0) && (LOAD_LAT > 1);
    assign ex_hit    = ex_valid && ex_memread &&
                       (((rs_a != '0) && (rs_a == ex_rd_w)) ||
                        ((rs_b != '0) && (rs_b == ex_rd_w)));
    assign sb_hit    = |{match_a_vec, match_b_vec};

    always_comb begin
        alloc_vec = '0;
        any_free  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (free_vec[i] && !any_free) begin
                alloc_vec[i] = alloc_req;
                any_free     = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        hazard_sb_entry u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .alloc     (alloc_vec[g]),
            .alloc_rd  (ex_rd_w),
            .alloc_cnt (SB_CNT_W'(LOAD_LAT - 1)),
            .rs_a      (rs_a),
            .rs_b      (rs_b),
            .free      (free_vec[g]),
            .match_a   (match_a_vec[g]),
            .match_b   (match_b_vec[g])
        );
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(alloc_req && !any_free));

    // Outputs are gated by rst_n so they drop asynchronously with reset.
    assign stall       = rst_n && id_valid && !flush && (ex_hit || sb_hit);
    assign ifid_hold   = stall;
    assign idex_bubble = rst_n && (stall || flush);

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed scoreboard bench running three latency configurations (1, 2, 3) on shared stimulus.
module tb_load_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        id_valid = 1'b0;
    logic [31:0] id_inst = '0;
    logic        flush = 1'b0;
    logic [2:0]  stall_v;
    logic [2:0]  hold_v;
    logic [2:0]  bubble_v;
    logic [31:0] cnt_v [3];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned exp_cnt [3];

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [6:0]  OPC        = 7'b0110011;
    localparam logic [31:0] ADD_X5_X1  = {7'b0, 5'd1, 5'd5, 3'b0, 5'd6, OPC};
    localparam logic [31:0] ADD_X1_X5  = {7'b0, 5'd5, 5'd1, 3'b0, 5'd6, OPC};
    localparam logic [31:0] ADD_X0_X0  = {7'b0, 5'd0, 5'd0, 3'b0, 5'd6, OPC};
    localparam logic [31:0] ADD_X7_X0  = {7'b0, 5'd0, 5'd7, 3'b0, 5'd8, OPC};
    localparam logic [31:0] LUI_X5_1   = {20'h00001, 5'd5, 7'b0110111};
    localparam logic [31:0] LUI_X5_28  = {20'h00028, 5'd5, 7'b0110111};
    localparam logic [31:0] ADDI_7_5   = {12'd5, 5'd7, 3'b0, 5'd6, 7'b0010011};
    localparam logic [31:0] SW_X5_X1   = {7'b0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
    localparam logic [31:0] JAL_RS1_5  = {12'h000, 5'd5, 3'b0, 5'd1, 7'b1101111};
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       fl;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .DEPTH(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall(stall_v[0]), .ifid_hold(hold_v[0]), .idex_bubble(bubble_v[0]), .stall_cnt(cnt_v[0])
    );
    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(2), .DEPTH(4)) u_l2 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall(stall_v[1]), .ifid_hold(hold_v[1]), .idex_bubble(bubble_v[1]), .stall_cnt(cnt_v[1])
    );
    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .DEPTH(2)) u_l3 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall(stall_v[2]), .ifid_hold(hold_v[2]), .idex_bubble(bubble_v[2]), .stall_cnt(cnt_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp_st bit order is {LOAD_LAT=3, LOAD_LAT=2, LOAD_LAT=1}; observed is {stall, ifid_hold, idex_bubble}.
    task automatic step(input string tag, input logic exv, input logic exm, input logic [4:0] exrd,
                        input logic idv, input logic [31:0] inst, input logic fl, input logic [2:0] exp_st);
        exp_t e;
        @(posedge clk);
        #1;
        ex_valid   = exv;
        ex_memread = exm;
        ex_rd      = exrd;
        id_valid   = idv;
        id_inst    = inst;
        flush      = fl;
        exp_q.push_back('{tag: tag, st: exp_st, fl: fl});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s_l%0d", e.tag, i + 1),
                      {29'd0, stall_v[i], hold_v[i], bubble_v[i]},
                      {29'd0, e.st[i], e.st[i], (e.st[i] | e.fl) & rst_n});
                if (rst_n && e.st[i]) exp_cnt[i]++;
            end
        end
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_cnt_l%0d", tag, i + 1), cnt_v[i], STATS ? 32'(exp_cnt[i]) : 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;

        // Reset held with hazard-looking inputs and a flush: every output must stay low.
        step("reset", 1, 1, 5'd5, 1, ADD_X5_X1, 1, 3'b000);
        check_counts("reset");
        #2 rst_n = 1'b1;

        // lw x5 ; add x6,x5,x1 back to back
        step("lu_a0", 1, 1, 5'd5, 1, ADD_X5_X1, 0, 3'b111);
        step("lu_a1", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b110);
        step("lu_a2", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b100);
        step("lu_a3", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b000);

        // lw x5 ; nop ; add x6,x1,x5
        step("gap_b0", 1, 1, 5'd5, 1, NOP, 0, 3'b000);
        step("gap_b1", 1, 0, 5'd0, 1, ADD_X1_X5, 0, 3'b110);
        step("gap_b2", 0, 0, 5'd0, 1, ADD_X1_X5, 0, 3'b100);
        step("gap_b3", 0, 0, 5'd0, 1, ADD_X1_X5, 0, 3'b000);

        // x0 destination and non-reading operand fields
        step("x0_c0", 1, 1, 5'd0, 1, ADD_X0_X0, 0, 3'b000);
        step("x0_c1", 0, 0, 5'd0, 1, ADD_X0_X0, 0, 3'b000);
        step("lui_d0", 1, 1, 5'd5, 1, LUI_X5_1, 0, 3'b000);
        step("lui_d1", 0, 0, 5'd0, 1, LUI_X5_28, 0, 3'b000);
        step("addi_d2", 1, 1, 5'd5, 1, ADDI_7_5, 0, 3'b000);
        step("sw_d3", 0, 0, 5'd0, 1, SW_X5_X1, 0, 3'b110);
        step("jal_d4", 0, 0, 5'd0, 1, JAL_RS1_5, 0, 3'b000);
        step("sw_d5", 0, 0, 5'd0, 1, SW_X5_X1, 0, 3'b000);

        // invalid ID instruction never stalls
        step("idv_e0", 1, 1, 5'd5, 0, ADD_X5_X1, 0, 3'b000);
        step("idv_e1", 0, 0, 5'd0, 0, ADD_X5_X1, 0, 3'b000);
        step("idv_e2", 0, 0, 5'd0, 0, ADD_X5_X1, 0, 3'b000);

        // flush suppresses the stall but the entry keeps aging
        step("fl_f0", 1, 1, 5'd5, 1, ADD_X5_X1, 0, 3'b111);
        step("fl_f1", 0, 0, 5'd0, 1, ADD_X5_X1, 1, 3'b000);
        step("fl_f2", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b100);
        step("fl_f3", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b000);

        // back-to-back loads fill DEPTH=2 at LOAD_LAT=3; third load reuses the expiring slot
        step("full_g0", 1, 1, 5'd5, 1, NOP, 0, 3'b000);
        step("full_g1", 1, 1, 5'd6, 1, NOP, 0, 3'b000);
        step("full_g2", 1, 1, 5'd7, 1, NOP, 0, 3'b000);
        step("full_g3", 0, 0, 5'd0, 1, ADD_X7_X0, 0, 3'b110);
        step("full_g4", 0, 0, 5'd0, 1, ADD_X7_X0, 0, 3'b100);
        step("full_g5", 0, 0, 5'd0, 1, ADD_X7_X0, 0, 3'b000);
        check_counts("pre_reset");

        // asynchronous reset in the middle of a stall
        step("rst_r0", 1, 1, 5'd5, 1, ADD_X5_X1, 0, 3'b111);
        step("rst_r1", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b110);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("async_rst_l%0d", i + 1), {29'd0, stall_v[i], hold_v[i], bubble_v[i]}, 32'd0);
        check_counts("async_rst");
        step("rst_hold", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b000);
        #2 rst_n = 1'b1;
        step("post_rst", 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b000);

        // four load-use pairs for the statistics counter
        for (int p = 0; p < 4; p++) begin
            step($sformatf("pair%0d_0", p), 1, 1, 5'd5, 1, ADD_X5_X1, 0, 3'b111);
            step($sformatf("pair%0d_1", p), 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b110);
            step($sformatf("pair%0d_2", p), 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b100);
            step($sformatf("pair%0d_3", p), 0, 0, 5'd0, 1, ADD_X5_X1, 0, 3'b000);
        end
        step("idle", 0, 0, 5'd0, 0, NOP, 0, 3'b000);
        check("stats_l2", cnt_v[1], STATS ? 32'd8 : 32'd0);
        check_counts("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
